// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: runtime-configurable UART transmitter with a one-entry holding
// buffer. Frames are start, 1..DBIT_MAX data bits (LSB first), optional
// even/odd parity, then 1 or 2 stop bits. Bit timing is OS_TICK s_ticks.
module uart_tx_cfg #(
    parameter int DBIT_MAX = 8,
    parameter int OS_TICK  = 16
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            s_tick,
    input  logic [DBIT_MAX-1:0]             tx_data,
    input  logic                            tx_valid,
    output logic                            tx_ready,
    input  logic [$clog2(DBIT_MAX+1)-1:0]   cfg_dbits,
    input  logic [1:0]                      cfg_parity,
    input  logic                            cfg_stop2,
    output logic                            tx,
    output logic                            busy,
    output logic                            tx_done_tick
);

    localparam int CW = $clog2(DBIT_MAX + 1);
    localparam int TW = $clog2(2 * OS_TICK);
    localparam logic [TW-1:0] BIT_LAST   = TW'(OS_TICK - 1);
    localparam logic [TW-1:0] STOP2_LAST = TW'(2 * OS_TICK - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q, state_d;
    logic [TW-1:0]         tick_q, tick_d;
    logic [CW-1:0]         bit_q, bit_d;
    logic [DBIT_MAX-1:0]   sh_q, sh_d;
    logic [DBIT_MAX-1:0]   buf_q, buf_d;
    logic                  full_q, full_d;
    logic [CW-1:0]         nb_q, nb_d;
    logic                  pen_q, pen_d;
    logic                  pbit_q, pbit_d;
    logic                  st2_q, st2_d;
    logic                  tx_q, tx_d;
    logic                  done_q, done_d;

    logic [CW-1:0]         eff_dbits;
    logic                  par_x;
    logic                  accept, load, bit_end, stop_last;

    // Frame width and parity of the buffered byte, used only at a load.
    always_comb begin
        if (cfg_dbits == '0 || cfg_dbits > CW'(DBIT_MAX))
            eff_dbits = CW'(DBIT_MAX);
        else
            eff_dbits = cfg_dbits;
        par_x = 1'b0;
        for (int i = 0; i < DBIT_MAX; i++)
            if (CW'(i) < eff_dbits) par_x = par_x ^ buf_q[i];
    end

    assign accept    = tx_valid && !full_q;
    assign bit_end   = s_tick && (tick_q == BIT_LAST);
    assign stop_last = (state_q == STOP) && s_tick &&
                       (tick_q == (st2_q ? STOP2_LAST : BIT_LAST));
    assign load      = full_q && ((state_q == IDLE) || stop_last);

    // Next-state, counters, shifter, buffer and the value tx takes next.
    always_comb begin
        state_d = state_q;
        tick_d  = s_tick ? tick_q + TW'(1) : tick_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        nb_d    = nb_q;
        pen_d   = pen_q;
        pbit_d  = pbit_q;
        st2_d   = st2_q;
        done_d  = 1'b0;
        buf_d   = accept ? tx_data : buf_q;
        full_d  = load ? 1'b0 : (accept ? 1'b1 : full_q);

        case (state_q)
            IDLE: tick_d = '0;
            START: if (bit_end) begin
                state_d = DATA;
                tick_d  = '0;
            end
            DATA: if (bit_end) begin
                tick_d = '0;
                sh_d   = sh_q >> 1;
                bit_d  = bit_q + CW'(1);
                if (bit_q == nb_q - CW'(1))
                    state_d = pen_q ? PARITY : STOP;
            end
            PARITY: if (bit_end) begin
                state_d = STOP;
                tick_d  = '0;
            end
            STOP: if (stop_last) begin
                done_d  = 1'b1;
                state_d = IDLE;
                tick_d  = '0;
            end
            default: begin
                state_d = IDLE;
                tick_d  = '0;
                bit_d   = '0;
            end
        endcase

        // A load overrides the per-state decisions, including the STOP exit.
        if (load) begin
            state_d = START;
            tick_d  = '0;
            bit_d   = '0;
            sh_d    = buf_q;
            nb_d    = eff_dbits;
            pen_d   = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
            pbit_d  = par_x ^ (cfg_parity == 2'b10);
            st2_d   = cfg_stop2;
        end

        // tx is registered from the next state so it never lags the state.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = sh_d[0];
            PARITY:  tx_d = pbit_d;
            default: tx_d = 1'b1;
        endcase
    end

    // State and datapath registers; reset drops the buffer and idles the line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            buf_q   <= '0;
            full_q  <= 1'b0;
            nb_q    <= CW'(DBIT_MAX);
            pen_q   <= 1'b0;
            pbit_q  <= 1'b0;
            st2_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            buf_q   <= buf_d;
            full_q  <= full_d;
            nb_q    <= nb_d;
            pen_q   <= pen_d;
            pbit_q  <= pbit_d;
            st2_q   <= st2_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign tx           = tx_q;
    assign tx_done_tick = done_q;
    assign busy         = (state_q != IDLE);
    assign tx_ready     = !full_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: a line monitor rebuilds each frame from
// tx sampled per s_tick and the test compares it with hand-built vectors.
module tb_uart_tx_cfg;

    localparam int DBIT_MAX = 8;
    localparam int OS_TICK  = 16;
    localparam int CW       = $clog2(DBIT_MAX + 1);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          s_tick = 1'b0;
    logic [7:0]    tx_data = '0;
    logic          tx_valid = 1'b0;
    logic [CW-1:0] cfg_dbits = CW'(8);
    logic [1:0]    cfg_parity = 2'b00;
    logic          cfg_stop2 = 1'b0;
    logic          tx, tx_ready, busy, tx_done_tick;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_cfg #(.DBIT_MAX(DBIT_MAX), .OS_TICK(OS_TICK)) dut (
        .clk(clk), .reset_n(reset_n), .s_tick(s_tick),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .cfg_dbits(cfg_dbits), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
        .tx(tx), .busy(busy), .tx_done_tick(tx_done_tick)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // s_tick: one cycle in three, changed just after the clock edge.
    initial begin
        int cyc;
        cyc = 0;
        forever begin
            @(posedge clk); #2;
            s_tick = (cyc % 3 == 2);
            cyc++;
        end
    end

    // line monitor
    logic [15:0] fq_vec[$];
    int          fq_tk[$];
    bit          fq_gl[$];
    bit          fq_b2b[$];
    bit          mon_in = 0;
    int          mon_tk = 0;
    logic [15:0] mon_vec = '0;
    logic [15:0] mon_seen = '0;
    bit          mon_gl = 0;
    int          done_cnt = 0;

    task automatic mon_rec(input int idx);
        if (idx < 16) begin
            if (mon_seen[idx]) begin
                if (mon_vec[idx] !== tx) mon_gl = 1;
            end else begin
                mon_seen[idx] = 1'b1;
                mon_vec[idx]  = tx;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            if (!reset_n) begin
                mon_in = 0;
            end else begin
                if (tx_done_tick) done_cnt++;
                if (mon_in && s_tick) mon_tk++;
                if (mon_in && tx_done_tick) begin
                    fq_vec.push_back(mon_vec);
                    fq_tk.push_back(mon_tk);
                    fq_gl.push_back(mon_gl);
                    fq_b2b.push_back(tx == 1'b0);
                    mon_in = 0;
                end else if (mon_in) begin
                    mon_rec(mon_tk / OS_TICK);
                end
                if (!mon_in && tx == 1'b0) begin
                    mon_in = 1; mon_tk = 0; mon_vec = '0; mon_seen = '0; mon_gl = 0;
                    mon_rec(0);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic send(input logic [7:0] d);
        int n;
        n = 0;
        while (!tx_ready && n < 3000) begin step(); n++; end
        if (!tx_ready) chk("send_ready_timeout", 0, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
    endtask

    task automatic wait_frames(input string tag, input int n);
        int k;
        k = 0;
        while (fq_vec.size() < n && k < 4000) begin step(); k++; end
        chk({tag, "_frames"}, fq_vec.size(), n);
    endtask

    task automatic check_frame(input string tag, input logic [15:0] vec, input int tk, input bit b2b);
        if (fq_vec.size() == 0) begin
            chk({tag, "_missing"}, 0, 1);
            return;
        end
        chk({tag, "_bits"},  fq_vec.pop_front(), vec);
        chk({tag, "_ticks"}, fq_tk.pop_front(), tk);
        chk({tag, "_glitch"}, fq_gl.pop_front(), 0);
        chk({tag, "_b2b"},   fq_b2b.pop_front(), b2b);
    endtask

    initial begin
        int d0, lows, k;

        // reset
        repeat (3) @(posedge clk); #2;
        chk("rst_tx", tx, 1);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", tx_done_tick, 0);
        reset_n = 1'b1;
        step();

        // basic 8N1 0xA5 with start latency
        d0 = done_cnt;
        send(8'hA5);
        chk("acc_ready", tx_ready, 0);
        chk("acc_busy", busy, 0);
        chk("acc_tx", tx, 1);
        step();
        chk("ld_ready", tx_ready, 1);
        chk("ld_busy", busy, 1);
        chk("ld_tx", tx, 0);
        wait_frames("a5", 1);
        check_frame("a5", 16'h34A, 160, 0);
        repeat (20) step();
        chk("a5_done_cnt", done_cnt - d0, 1);
        chk("a5_idle_busy", busy, 0);

        // parity: 7E2 then 7O1
        cfg_dbits = CW'(7); cfg_parity = 2'b01; cfg_stop2 = 1'b1;
        send(8'h55);
        wait_frames("7e2", 1);
        check_frame("7e2", 16'h6AA, 176, 0);
        cfg_parity = 2'b10; cfg_stop2 = 1'b0;
        send(8'h55);
        wait_frames("7o1", 1);
        check_frame("7o1", 16'h3AA, 160, 0);

        // back-to-back 0x01, 0x80
        cfg_dbits = CW'(8); cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        send(8'h01);
        send(8'h80);
        repeat (60) step();
        chk("b2b_ready_low", tx_ready, 0);
        lows = 0; k = 0;
        while (fq_vec.size() < 2 && k < 4000) begin
            step();
            if (!busy && fq_vec.size() < 2) lows++;
            k++;
        end
        chk("b2b_busy_gap", lows, 0);
        check_frame("b2b1", 16'h202, 160, 1);
        check_frame("b2b2", 16'h300, 160, 0);

        // config latched at load, changed mid-DATA
        send(8'hFF);
        repeat (150) step();
        chk("cl_mid_busy", busy, 1);
        cfg_dbits = CW'(5); cfg_parity = 2'b10; cfg_stop2 = 1'b1;
        send(8'h1F);
        wait_frames("cl", 2);
        check_frame("cl_8n1", 16'h3FE, 160, 1);
        check_frame("cl_5o2", 16'h1BE, 144, 0);

        // dbits 0 and >DBIT_MAX fall back to 8; parity 11 is none
        cfg_dbits = CW'(0); cfg_parity = 2'b11; cfg_stop2 = 1'b0;
        send(8'hC3);
        wait_frames("db0", 1);
        check_frame("db0", 16'h386, 160, 0);
        cfg_dbits = CW'(12);
        send(8'hC3);
        wait_frames("db12", 1);
        check_frame("db12", 16'h386, 160, 0);

        // reset during data bit 3 with the buffer full
        cfg_dbits = CW'(8); cfg_parity = 2'b00;
        send(8'hF0);
        send(8'h5A);
        k = 0;
        while (!(mon_in && mon_tk >= 72) && k < 4000) begin step(); k++; end
        chk("rst_pre_tx", tx, 0);
        chk("rst_pre_ready", tx_ready, 0);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_tx", tx, 1);
        chk("rst_mid_ready", tx_ready, 1);
        chk("rst_mid_busy", busy, 0);
        repeat (2) step();
        reset_n = 1'b1;
        lows = 0;
        repeat (600) begin
            step();
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        chk("rst_quiet", lows, 0);
        chk("rst_no_frame", fq_vec.size(), 0);
        send(8'h5A);
        wait_frames("post_rst", 1);
        check_frame("post_rst", 16'h2B4, 160, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Runtime-configurable UART transmitter with a one-entry holding buffer and a valid/ready input handshake. It serialises frames of 1..DBIT_MAX data bits, LSB first, with optional even/odd parity and 1 or 2 stop bits. Bit timing comes from an external oversampling tick (OS_TICK ticks per bit) shared with the receiver's baud generator. It sits between the host-side byte source (FIFO or CPU register) and the serial pin, and supports back-to-back frames with no idle gap.

## Interface
- DBIT_MAX, 8, maximum data bits per frame; sets the tx_data width.
- OS_TICK, 16, s_tick pulses per bit period; must be ≥2.
- clk  in  1  system clock.
- reset_n  in  1  reset; asynchronous, active-low.
- s_tick  in  1  oversampling strobe, one clk cycle wide.
- tx_data  in  DBIT_MAX  frame payload; LSB is transmitted first.
- tx_valid  in  1  payload valid.
- tx_ready  out  1  holding buffer empty; a transfer occurs when tx_valid && tx_ready at a clk edge.
- cfg_dbits  in  $clog2(DBIT_MAX+1)  data bits per frame; 0 or values >DBIT_MAX mean DBIT_MAX.
- cfg_parity  in  2  00 = none, 01 = even, 10 = odd, 11 = none.
- cfg_stop2  in  1  0 = one stop bit, 1 = two stop bits.
- tx  out  1  serial line; idles high.
- busy  out  1  high in any state other than IDLE.
- tx_done_tick  out  1  one-cycle pulse at the end of each frame's last stop tick.

## Operation
- **Holding buffer**
  - Data register plus full flag. tx_ready = !full.
  - An accepted transfer captures tx_data and sets full.
  - Data is not accepted in the cycle the buffer is full, even if the buffer is loaded into the shifter at that edge.
- **Load event.** Occurs when the state is IDLE, or at the last STOP tick, while full=1. At that edge:
  - the shifter gets the buffer data and full clears;
  - cfg_dbits, cfg_parity and cfg_stop2 are latched into frame-local registers;
  - parity is latched: XOR of the low N data bits for even, its inverse for odd;
  - the tick counter and bit counter clear;
  - the state goes to START.
- **Config changes** mid-frame have no effect until the next load.
- **States:** IDLE → START → DATA → PARITY → STOP → IDLE, or STOP → START on a back-to-back load.
  - IDLE: tx=1. s_tick is ignored.
  - START: tx=0. After OS_TICK ticks, go to DATA.
  - DATA: tx=shifter[0]. Every OS_TICK ticks, shift right and increment the bit count. After N bits, go to PARITY if parity is enabled, else STOP.
  - PARITY: tx=latched parity bit, for OS_TICK ticks.
  - STOP: tx=1, for OS_TICK ticks (cfg_stop2=0) or 2·OS_TICK ticks (cfg_stop2=1). On the final tick, pulse tx_done_tick, then load if full, else go to IDLE.
- **Counters**
  - Tick counter width is $clog2(2·OS_TICK). It resets to 0 on every state change.
  - Bit counter width is $clog2(DBIT_MAX+1).
- **Registered outputs.** tx is a register updated on the same edge as the state, so tx reflects the current state with no extra cycle of lag. busy and tx_ready are decoded from registers.
- **Illegal state encodings** return to IDLE with tx=1.

## Timing
- **Reset values:** tx=1, tx_ready=1, busy=0, tx_done_tick=0, state IDLE, buffer empty.
- **Reset mid-frame:** the line returns high immediately and asynchronously, and the buffered byte is discarded.
- **Start latency:** with an accept at edge k from IDLE, full=1 after edge k, load at edge k+1, tx=0 and busy=1 after edge k+1, tx_ready=1 after edge k+1.
- **Bit length:** each bit lasts exactly OS_TICK s_ticks counted after the state entry edge. A tick coincident with the entry edge is not counted.
- **Frame length:** 1 + N + P + S bit periods, where P ∈ {0,1} and S ∈ {1,2}.
- **Back-to-back:** if full at the last STOP tick, tx_done_tick pulses and the next START begins at that same edge, with zero idle cycles between frames.
- **Simultaneous accept and frame end** with the buffer empty: the frame goes to IDLE, and the new byte loads on the following edge (one idle cycle).

## Test plan
- **Basic frame.** OS_TICK=16, cfg 8N1, send 0xA5 from idle.
  - Line reads 0,1,0,1,0,0,1,0,1,1, each bit 16 ticks long.
  - tx_done_tick fires once.
  - tx_ready returns high one cycle after the accept.
- **Parity.** cfg 7E2, send 0x55; then 7O1, send 0x55.
  - 7E2: 7 data bits, parity bit 0, stop high for 32 ticks.
  - 7O1: parity bit 1, stop high for 16 ticks.
- **Back-to-back.** Present 0x01 then 0x80 on consecutive ready windows, 8N1.
  - Second start bit begins at the same edge as the first tx_done_tick.
  - busy never drops between frames.
  - tx_ready is low between the 0x80 accept and its load.
- **Config latch.** Start an 8N1 frame of 0xFF and switch cfg to 5O2 mid-DATA.
  - Current frame completes as 8N1.
  - Next frame (0x1F) has 5 data bits, parity 0, and 2 stop bits.
- **Boundary.** Set cfg_dbits=0, and also cfg_dbits > DBIT_MAX; send 0xC3.
  - 8 data bits are sent in both cases.
  - cfg_parity=11 produces no parity bit.
- **Reset mid-frame.** Assert reset_n=0 during data bit 3 while the buffer is full.
  - tx=1 and tx_ready=1 immediately.
  - After release, there is no residual frame: tx stays high until a new accept.
